pipe_hazard_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage RV32 pipeline. It watches the decode, execute and writeback stages and drives the hold, bubble and flush controls of the PC, IF/DC and DC/EX registers. While DC/EX is held, it also patches the held rs1/rs2 operands with writeback results. It replaces ad-hoc stall wiring with one sequenced state machine that covers load-use, multi-cycle (mul/div) ops and taken branches.

---
 rtl/pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for the 5-stage RV32 pipeline. One sequenced
// state machine (RUN / LOAD_WAIT / MC_WAIT) covers load-use hazards,
// multi-cycle (mul/div) ops and taken branches. It drives the hold, bubble and
// flush controls of the PC, IF/DC and DC/EX registers. While DC/EX is held, it
// patches the held rs1/rs2 operands with writeback results.
//
// Control outputs are Mealy: they are combinational from the current state and
// the inputs, so they settle before the negedge pipeline latches.
//
// Parameters
//   LOAD_EXTRA   extra bubble cycles after the load-use detect cycle (0..3)
//   MC_TIMEOUT   maximum MC_WAIT cycles before a forced exit
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   dc_rs1/rs2_idx, _used         decode-stage source registers and use flags
//   ex_rd, ex_reg_write           EX destination and write enable
//   ex_is_load, ex_is_mc          EX instruction class
//   ex_rs1/rs2_idx                sources of the instruction held in DC/EX
//   mc_done                       multi-cycle result valid (1-cycle pulse)
//   ex_branch_taken               EX resolved a taken branch or jump
//   wb_rd, wb_reg_write, wb_data  writeback port
//   pc_stay, if_dc_stay,
//   dc_ex_stay                    hold the register
//   dc_ex_bubble                  DC/EX loads a NOP
//   if_dc_flush                   IF/DC loads a NOP
//   is_rs1/rs2_change             overwrite the held DC/EX operand
//   new_rs1/rs2_value             replacement operand (always wb_data)
//   mc_timeout                    sticky error flag, cleared only by reset
//   stall_cycles                  saturating count of cycles with pc_stay=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int LOAD_EXTRA = 1,
  parameter int MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dc_rs1_idx,
  input  logic [4:0]  dc_rs2_idx,
  input  logic        dc_rs1_used,
  input  logic        dc_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic        ex_is_mc,
  input  logic [4:0]  ex_rs1_idx,
  input  logic [4:0]  ex_rs2_idx,
  input  logic        mc_done,
  input  logic        ex_branch_taken,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_data,
  output logic        pc_stay,
  output logic        if_dc_stay,
  output logic        dc_ex_stay,
  output logic        dc_ex_bubble,
  output logic        if_dc_flush,
  output logic        is_rs1_change,
  output logic        is_rs2_change,
  output logic [31:0] new_rs1_value,
  output logic [31:0] new_rs2_value,
  output logic        mc_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    MC_WAIT   = 2'd2
  } state_e;

  localparam int              MC_W          = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [MC_W-1:0] MC_LAST       = MC_W'(MC_TIMEOUT - 1);
  localparam logic [1:0]      LOAD_CNT_INIT = (LOAD_EXTRA > 0) ? 2'(LOAD_EXTRA - 1) : 2'd0;

  state_e          state_q, state_d;
  logic [1:0]      load_cnt_q, load_cnt_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic            mc_timeout_q, mc_timeout_d;
  logic [15:0]     stall_cycles_q, stall_cycles_d;
  logic            load_use;

  // A load into x0 never produces a value anyone waits for.
  assign load_use = ex_is_load & ex_reg_write & (ex_rd != 5'd0) &
                    ((dc_rs1_used & (dc_rs1_idx == ex_rd)) |
                     (dc_rs2_used & (dc_rs2_idx == ex_rd)));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    mc_cnt_d     = mc_cnt_q;
    mc_timeout_d = mc_timeout_q;
    pc_stay      = 1'b0;
    if_dc_stay   = 1'b0;
    dc_ex_stay   = 1'b0;
    dc_ex_bubble = 1'b0;
    if_dc_flush  = 1'b0;

    unique case (state_q)
      RUN: begin
        // Branch outranks everything: the instructions behind it are dead, so
        // stalling for them would be wasted (this also settles mc+branch).
        if (ex_branch_taken) begin
          if_dc_flush  = 1'b1;
          dc_ex_bubble = 1'b1;
        end else if (ex_is_mc) begin
          pc_stay    = 1'b1;
          if_dc_stay = 1'b1;
          dc_ex_stay = 1'b1;
          mc_cnt_d   = '0;
          state_d    = MC_WAIT;
        end else if (load_use) begin
          pc_stay      = 1'b1;
          if_dc_stay   = 1'b1;
          dc_ex_bubble = 1'b1;
          if (LOAD_EXTRA > 0) begin
            load_cnt_d = LOAD_CNT_INIT;
            state_d    = LOAD_WAIT;
          end
        end
      end

      LOAD_WAIT: begin
        pc_stay      = 1'b1;
        if_dc_stay   = 1'b1;
        dc_ex_bubble = 1'b1;
        if (load_cnt_q == 2'd0) state_d = RUN;
        else                    load_cnt_d = load_cnt_q - 2'd1;
      end

      MC_WAIT: begin
        // Stays remain up through the exit cycle; the pipeline releases on
        // the following cycle, once the result is in place.
        pc_stay    = 1'b1;
        if_dc_stay = 1'b1;
        dc_ex_stay = 1'b1;
        if (mc_done) begin
          state_d = RUN;
        end else if (mc_cnt_q == MC_LAST) begin
          mc_timeout_d = 1'b1;
          state_d      = RUN;
        end else begin
          mc_cnt_d = mc_cnt_q + 1'b1;
        end
      end

      default: state_d = RUN;
    endcase

    stall_cycles_d = stall_cycles_q;
    if (pc_stay && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      load_cnt_q     <= '0;
      mc_cnt_q       <= '0;
      mc_timeout_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      mc_cnt_q       <= mc_cnt_d;
      mc_timeout_q   <= mc_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Operand patching only matters while DC/EX holds its operands; a write to
  // x0 carries no architectural value and never patches.
  assign is_rs1_change = dc_ex_stay & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == ex_rs1_idx);
  assign is_rs2_change = dc_ex_stay & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == ex_rs2_idx);
  assign new_rs1_value = wb_data;
  assign new_rs2_value = wb_data;

  assign mc_timeout   = mc_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (LOAD_EXTRA=1, MC_TIMEOUT=8).
// Each cycle the expected control vector, mc_timeout, stall count and patch
// value are pushed to a scoreboard when inputs are driven, then popped and
// compared at the following negedge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dc_rs1_idx, dc_rs2_idx;
  logic        dc_rs1_used, dc_rs2_used;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_load, ex_is_mc;
  logic [4:0]  ex_rs1_idx, ex_rs2_idx;
  logic        mc_done, ex_branch_taken;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        pc_stay, if_dc_stay, dc_ex_stay, dc_ex_bubble, if_dc_flush;
  logic        is_rs1_change, is_rs2_change;
  logic [31:0] new_rs1_value, new_rs2_value;
  logic        mc_timeout;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_EXTRA(1), .MC_TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .dc_rs1_idx     (dc_rs1_idx),
    .dc_rs2_idx     (dc_rs2_idx),
    .dc_rs1_used    (dc_rs1_used),
    .dc_rs2_used    (dc_rs2_used),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_is_load     (ex_is_load),
    .ex_is_mc       (ex_is_mc),
    .ex_rs1_idx     (ex_rs1_idx),
    .ex_rs2_idx     (ex_rs2_idx),
    .mc_done        (mc_done),
    .ex_branch_taken(ex_branch_taken),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_data        (wb_data),
    .pc_stay        (pc_stay),
    .if_dc_stay     (if_dc_stay),
    .dc_ex_stay     (dc_ex_stay),
    .dc_ex_bubble   (dc_ex_bubble),
    .if_dc_flush    (if_dc_flush),
    .is_rs1_change  (is_rs1_change),
    .is_rs2_change  (is_rs2_change),
    .new_rs1_value  (new_rs1_value),
    .new_rs2_value  (new_rs2_value),
    .mc_timeout     (mc_timeout),
    .stall_cycles   (stall_cycles)
  );

  // Control vector bits: {pc, if_dc, dc_ex stay, bubble, flush, rs1 chg, rs2 chg}
  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_LOAD  = 7'b110_1000;
  localparam logic [6:0] C_MC    = 7'b111_0000;
  localparam logic [6:0] C_FLUSH = 7'b000_1100;
  localparam logic [6:0] C_RS1   = 7'b000_0010;
  localparam logic [6:0] C_RS2   = 7'b000_0001;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic        to;
    logic [15:0] stall;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_stall = '0;
  logic        exp_to    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    dc_rs1_idx = '0; dc_rs2_idx = '0; dc_rs1_used = 1'b0; dc_rs2_used = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_is_mc = 1'b0;
    ex_rs1_idx = '0; ex_rs2_idx = '0; mc_done = 1'b0; ex_branch_taken = 1'b0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    dc_rs1_idx = rs1; dc_rs1_used = u1; dc_rs2_idx = rs2; dc_rs2_used = u2;
  endtask

  // One clock cycle: inputs are already driven; record expectations, compare
  // at negedge, then advance to just after the next posedge.
  task automatic cycle(input string tag, input logic [6:0] ctl);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.to = exp_to; e.stall = exp_stall; e.val = wb_data;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".ctl"}, 32'({pc_stay, if_dc_stay, dc_ex_stay, dc_ex_bubble,
                                if_dc_flush, is_rs1_change, is_rs2_change}), 32'(e.ctl));
    check({e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.stall));
    check({e.tag, ".mc_timeout"}, 32'(mc_timeout), 32'(e.to));
    check({e.tag, ".new_rs1"}, new_rs1_value, e.val);
    check({e.tag, ".new_rs2"}, new_rs2_value, e.val);
    if (reset) begin
      exp_stall = '0;
      exp_to    = 1'b0;
    end else if (ctl[6] && exp_stall != 16'hFFFF) begin
      exp_stall = exp_stall + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    cycle("reset", C_NONE);
    reset = 1'b0;
    cycle("idle", C_NONE);

    // Load-use via rs1: lw x5 in EX, add x6,x5,x1 in decode -> 2 stall cycles.
    set_load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    cycle("lu_detect", C_LOAD);
    cycle("lu_extra", C_LOAD);
    idle_inputs();
    cycle("lu_after", C_NONE);
    check("lu_stall_total", 32'(stall_cycles), 32'd2);

    // Load-use via rs2 only.
    set_load_use(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);
    cycle("lu2_detect", C_LOAD);
    cycle("lu2_extra", C_LOAD);
    idle_inputs();
    cycle("lu2_after", C_NONE);

    // No-hazard variants: rd=x0, unused sources, non-load, no reg write.
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    cycle("lu_x0", C_NONE);
    set_load_use(5'd5, 5'd5, 1'b0, 5'd5, 1'b0);
    cycle("lu_unused", C_NONE);
    set_load_use(5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
    ex_is_load = 1'b0;
    cycle("not_load", C_NONE);
    ex_is_load = 1'b1; ex_reg_write = 1'b0;
    cycle("no_wr", C_NONE);
    idle_inputs();

    // mul: mc_done on 4th MC_WAIT cycle, WB writes x7 where ex_rs2_idx=7.
    ex_is_mc = 1'b1; ex_rs1_idx = 5'd0; ex_rs2_idx = 5'd7;
    cycle("mc_detect", C_MC);
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'h1111_2222;
    cycle("mc_w1_x0", C_MC);
    wb_reg_write = 1'b0; wb_rd = 5'd7; wb_data = 32'h3333_4444;
    cycle("mc_w2_nowr", C_MC);
    wb_reg_write = 1'b1; wb_rd = 5'd6; wb_data = 32'h5555_6666;
    cycle("mc_w3_other", C_MC);
    mc_done = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    cycle("mc_w4_done", C_MC | C_RS2);
    ex_is_mc = 1'b0; mc_done = 1'b0;
    cycle("mc_after_nopatch", C_NONE);
    idle_inputs();

    // Taken branch together with a load-use hazard: flush wins, stays in RUN.
    set_load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    ex_branch_taken = 1'b1;
    cycle("br_lu", C_FLUSH);
    idle_inputs();
    cycle("br_lu_after", C_NONE);

    // Branch with ex_is_mc: branch wins, no MC_WAIT.
    ex_is_mc = 1'b1; ex_branch_taken = 1'b1;
    cycle("br_mc", C_FLUSH);
    idle_inputs();
    cycle("br_mc_after", C_NONE);

    // Timeout: no mc_done, forced exit after 8 MC_WAIT cycles.
    ex_is_mc = 1'b1; ex_rs1_idx = 5'd9; ex_rs2_idx = 5'd4;
    cycle("to_detect", C_MC);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 32'hCAFE_F00D;
        cycle($sformatf("to_w%0d_rs1", i), C_MC | C_RS1);
      end else begin
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'(i);
        cycle($sformatf("to_w%0d", i), C_MC);
      end
    end
    exp_to = 1'b1;
    idle_inputs();
    cycle("to_exit", C_NONE);
    cycle("to_sticky", C_NONE);

    // Reset in the 2nd MC_WAIT cycle clears state, counters and mc_timeout.
    ex_is_mc = 1'b1;
    cycle("rst_detect", C_MC);
    cycle("rst_w1", C_MC);
    reset = 1'b1;
    cycle("rst_w2", C_MC);
    reset = 1'b0;
    idle_inputs();
    cycle("rst_after", C_NONE);
    cycle("rst_after2", C_NONE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
